// File: rtl/proposal_sram_writer.sv
// Write-side packer for the 16x128b proposal SRAM: coalesces single-byte proposals
// that fall in the same line into one masked SRAM write, with a flush drain handshake.
module proposal_sram_writer #(
  parameter int ADDR_SPACE = 4,
  parameter int Q          = 16,
  parameter int BW         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_SPACE+3:0] in_idx,
  input  logic [BW-1:0]         in_data,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  wsb,
  output logic [ADDR_SPACE-1:0] waddr,
  output logic [BW*Q-1:0]       wdata,
  output logic [Q-1:0]          bytemask
);

  typedef enum logic [1:0] {EMPTY, ACC, FLUSH2} state_t;

  state_t                state_q, state_d;
  logic [ADDR_SPACE-1:0] bufAddr_q, bufAddr_d;
  logic [BW*Q-1:0]       bufData_q, bufData_d;
  logic [Q-1:0]          bufPend_q, bufPend_d;

  logic                  wsb_q;
  logic [ADDR_SPACE-1:0] waddr_q;
  logic [BW*Q-1:0]       wdata_q;
  logic [Q-1:0]          bytemask_q;
  logic                  flushDone_q;

  logic                  accept;
  logic                  flushAcc;
  logic                  sameLine;
  logic [ADDR_SPACE-1:0] inLine;
  logic [Q-1:0]          laneSel;
  logic [Q-1:0]          mergedPend;
  logic [BW*Q-1:0]       mergedData;
  logic [BW*Q-1:0]       newData;

  logic                  wrReq;
  logic                  doneReq;
  logic [ADDR_SPACE-1:0] wrAddr;
  logic [Q-1:0]          wrPend;
  logic [BW*Q-1:0]       wrData;
  logic [BW*Q-1:0]       wrDataMasked;

  assign in_ready   = rst_n && (state_q != FLUSH2);
  assign accept     = in_valid && in_ready;
  assign flushAcc   = flush && in_ready;
  assign inLine     = in_idx[ADDR_SPACE+3:4];
  assign sameLine   = (inLine == bufAddr_q);
  assign laneSel    = Q'(1) << in_idx[3:0];
  assign mergedPend = bufPend_q | laneSel;

  // Lane merge of the incoming byte, both into the current buffer and into a fresh one
  always_comb begin
    mergedData = bufData_q;
    newData    = '0;
    for (int i = 0; i < Q; i++) begin
      if (laneSel[i]) begin
        mergedData[i*BW +: BW] = in_data;
        newData[i*BW +: BW]    = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      bufAddr_q <= '0;
      bufData_q <= '0;
      bufPend_q <= '0;
    end else begin
      state_q   <= state_d;
      bufAddr_q <= bufAddr_d;
      bufData_q <= bufData_d;
      bufPend_q <= bufPend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bufAddr_d = bufAddr_q;
    bufData_d = bufData_q;
    bufPend_d = bufPend_q;
    case (state_q)
      EMPTY: begin
        if (accept && !flushAcc) begin
          state_d   = ACC;
          bufAddr_d = inLine;
          bufData_d = newData;
          bufPend_d = laneSel;
        end
      end
      ACC: begin
        if (accept && !sameLine) begin
          state_d   = flushAcc ? FLUSH2 : ACC;
          bufAddr_d = inLine;
          bufData_d = newData;
          bufPend_d = laneSel;
        end else if (accept) begin
          if (flushAcc || (&mergedPend)) begin
            state_d   = EMPTY;
            bufPend_d = '0;
          end else begin
            bufData_d = mergedData;
            bufPend_d = mergedPend;
          end
        end else if (flushAcc) begin
          state_d   = EMPTY;
          bufPend_d = '0;
        end
      end
      FLUSH2: begin
        state_d   = EMPTY;
        bufPend_d = '0;
      end
      default: begin
        state_d   = EMPTY;
        bufPend_d = '0;
      end
    endcase
  end

  // Write decision for the next cycle; the default fields describe the buffered line
  always_comb begin
    wrReq   = 1'b0;
    doneReq = 1'b0;
    wrAddr  = bufAddr_q;
    wrPend  = bufPend_q;
    wrData  = bufData_q;
    case (state_q)
      EMPTY: begin
        if (accept && flushAcc) begin
          wrReq   = 1'b1;
          doneReq = 1'b1;
          wrAddr  = inLine;
          wrPend  = laneSel;
          wrData  = newData;
        end else if (flushAcc) begin
          doneReq = 1'b1;
        end
      end
      ACC: begin
        if (accept && !sameLine) begin
          wrReq = 1'b1;
        end else if (accept) begin
          if (flushAcc || (&mergedPend)) begin
            wrReq   = 1'b1;
            doneReq = flushAcc;
            wrPend  = mergedPend;
            wrData  = mergedData;
          end
        end else if (flushAcc) begin
          wrReq   = 1'b1;
          doneReq = 1'b1;
        end
      end
      FLUSH2: begin
        wrReq   = 1'b1;
        doneReq = 1'b1;
      end
      default: begin
        wrReq   = 1'b0;
        doneReq = 1'b0;
      end
    endcase
  end

  always_comb begin
    wrDataMasked = '0;
    for (int i = 0; i < Q; i++) begin
      if (wrPend[i]) wrDataMasked[i*BW +: BW] = wrData[i*BW +: BW];
    end
  end

  // Registered SRAM port; address and data hold their last value between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsb_q       <= 1'b1;
      waddr_q     <= '0;
      wdata_q     <= '0;
      bytemask_q  <= '1;
      flushDone_q <= 1'b0;
    end else begin
      flushDone_q <= doneReq;
      if (wrReq) begin
        wsb_q      <= 1'b0;
        waddr_q    <= wrAddr;
        wdata_q    <= wrDataMasked;
        bytemask_q <= ~wrPend;
      end else begin
        wsb_q      <= 1'b1;
        bytemask_q <= '1;
      end
    end
  end

  assign wsb        = wsb_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign bytemask   = bytemask_q;
  assign flush_done = flushDone_q;

endmodule

// File: tb/tb_proposal_sram_writer.sv
// Self-checking bench for proposal_sram_writer: directed scenarios plus random traffic
// compared against a line-buffer reference model built from byte arrays.
module tb_proposal_sram_writer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_idx = '0;
  logic [7:0]   in_data = '0;
  logic         flush = 1'b0;
  logic         flush_done;
  logic         wsb;
  logic [3:0]   waddr;
  logic [127:0] wdata;
  logic [15:0]  bytemask;

  int checks = 0;
  int errors = 0;

  // Reference model: one open line held as plain byte/flag arrays
  bit       mOpen;
  bit       mF2;
  int       mLine;
  bit [7:0] mBytes [16];
  bit       mPend  [16];

  logic         eWsb;
  logic [15:0]  eMask;
  logic [3:0]   eAddr;
  logic [127:0] eData;
  logic         eDone;

  always #5 clk = ~clk;

  proposal_sram_writer #(.ADDR_SPACE(4), .Q(16), .BW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_idx     (in_idx),
    .in_data    (in_data),
    .flush      (flush),
    .flush_done (flush_done),
    .wsb        (wsb),
    .waddr      (waddr),
    .wdata      (wdata),
    .bytemask   (bytemask)
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mOpen = 1'b0;
    mF2   = 1'b0;
    mLine = 0;
    for (int i = 0; i < 16; i++) begin
      mBytes[i] = 8'h00;
      mPend[i]  = 1'b0;
    end
    eWsb  = 1'b1;
    eMask = 16'hFFFF;
    eAddr = 4'h0;
    eData = '0;
    eDone = 1'b0;
  endtask

  task automatic openLine(input int line);
    mOpen = 1'b1;
    mLine = line;
    for (int i = 0; i < 16; i++) mPend[i] = 1'b0;
  endtask

  task automatic emitWrite();
    eWsb  = 1'b0;
    eAddr = 4'(mLine);
    eData = '0;
    for (int i = 0; i < 16; i++) begin
      eMask[i] = !mPend[i];
      if (mPend[i]) eData[i*8 +: 8] = mBytes[i];
    end
  endtask

  function automatic bit allPend();
    bit r = 1'b1;
    for (int i = 0; i < 16; i++) if (!mPend[i]) r = 1'b0;
    return r;
  endfunction

  task automatic modelStep(input bit v, input logic [7:0] idx, input logic [7:0] d, input bit fl);
    int line = int'(idx[7:4]);
    int lane = int'(idx[3:0]);
    eWsb  = 1'b1;
    eMask = 16'hFFFF;
    eDone = 1'b0;
    if (mF2) begin
      emitWrite();
      mOpen = 1'b0;
      mF2   = 1'b0;
      eDone = 1'b1;
    end else if (v) begin
      if (mOpen && line != mLine) begin
        emitWrite();
        openLine(line);
        mBytes[lane] = d;
        mPend[lane]  = 1'b1;
        if (fl) mF2 = 1'b1;
      end else begin
        if (!mOpen) openLine(line);
        mBytes[lane] = d;
        mPend[lane]  = 1'b1;
        if (fl || allPend()) begin
          emitWrite();
          mOpen = 1'b0;
          eDone = fl;
        end
      end
    end else if (fl) begin
      if (mOpen) begin
        emitWrite();
        mOpen = 1'b0;
      end
      eDone = 1'b1;
    end
  endtask

  task automatic compareAll();
    checkOutput("wsb", wsb, eWsb);
    checkOutput("bytemask", bytemask, eMask);
    checkOutput("flush_done", flush_done, eDone);
    checkOutput("waddr", waddr, eAddr);
    checkOutput("wdata", wdata, eData);
  endtask

  // Drive one cycle of input at the falling edge, then compare at the next falling edge
  task automatic applyStimulus(input bit v, input logic [7:0] idx, input logic [7:0] d, input bit fl);
    in_valid = v;
    in_idx   = idx;
    in_data  = d;
    flush    = fl;
    #1;
    checkOutput("in_ready", in_ready, !mF2);
    modelStep(v, idx, d, fl);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    compareAll();
  endtask

  initial begin
    logic [127:0] expW;
    modelReset();

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_wsb", wsb, 1'b1);
    checkOutput("rst_mask", bytemask, 16'hFFFF);
    checkOutput("rst_ready", in_ready, 1'b0);
    checkOutput("rst_done", flush_done, 1'b0);
    checkOutput("rst_waddr", waddr, 4'h0);
    checkOutput("rst_wdata", wdata, 128'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);

    // Coalesce bytes of line 3, then a line-5 byte evicts it
    applyStimulus(1'b1, 8'h31, 8'hAA, 1'b0);
    applyStimulus(1'b1, 8'h35, 8'hBB, 1'b0);
    applyStimulus(1'b1, 8'h31, 8'hCC, 1'b0);
    checkOutput("coal_nowr", wsb, 1'b1);
    applyStimulus(1'b1, 8'h52, 8'h11, 1'b0);
    expW = (128'hBB << 40) | (128'hCC << 8);
    checkOutput("coal_wsb", wsb, 1'b0);
    checkOutput("coal_waddr", waddr, 4'h3);
    checkOutput("coal_mask", bytemask, 16'hFFDD);
    checkOutput("coal_wdata", wdata, expW);

    // Full line 7 writes itself out
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h70 + i), 8'(8'h70 + i), 1'b0);
    checkOutput("full_wsb", wsb, 1'b0);
    checkOutput("full_waddr", waddr, 4'h7);
    checkOutput("full_mask", bytemask, 16'h0000);
    checkOutput("full_wdata", wdata, 128'h7F7E7D7C7B7A79787776757473727170);
    applyStimulus(1'b1, 8'h80, 8'h42, 1'b0);
    checkOutput("full_next_nowr", wsb, 1'b1);

    // Flush together with a same-line byte
    applyStimulus(1'b1, 8'h20, 8'h5A, 1'b0);
    applyStimulus(1'b1, 8'h21, 8'h6B, 1'b1);
    checkOutput("fsame_wsb", wsb, 1'b0);
    checkOutput("fsame_waddr", waddr, 4'h2);
    checkOutput("fsame_mask", bytemask, 16'hFFFC);
    checkOutput("fsame_wdata", wdata, 128'h6B5A);
    checkOutput("fsame_done", flush_done, 1'b1);

    // Flush together with a different-line byte takes two writes
    applyStimulus(1'b1, 8'h20, 8'h5A, 1'b0);
    applyStimulus(1'b1, 8'h91, 8'h77, 1'b1);
    checkOutput("fdiff1_waddr", waddr, 4'h2);
    checkOutput("fdiff1_mask", bytemask, 16'hFFFE);
    checkOutput("fdiff1_ready", in_ready, 1'b0);
    checkOutput("fdiff1_done", flush_done, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("fdiff2_wsb", wsb, 1'b0);
    checkOutput("fdiff2_waddr", waddr, 4'h9);
    checkOutput("fdiff2_mask", bytemask, 16'hFFFD);
    checkOutput("fdiff2_wdata", wdata, 128'h7700);
    checkOutput("fdiff2_done", flush_done, 1'b1);
    checkOutput("fdiff2_ready", in_ready, 1'b1);

    // Reset in the middle of a two-cycle flush
    applyStimulus(1'b1, 8'h20, 8'h5A, 1'b0);
    applyStimulus(1'b1, 8'h91, 8'h77, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_wsb", wsb, 1'b1);
    checkOutput("mrst_mask", bytemask, 16'hFFFF);
    checkOutput("mrst_done", flush_done, 1'b0);
    checkOutput("mrst_ready", in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("mrst_wsb2", wsb, 1'b1);
    checkOutput("mrst_done2", flush_done, 1'b0);
    rst_n = 1'b1;
    modelReset();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("mrst_flush_done", flush_done, 1'b1);
    checkOutput("mrst_flush_nowr", wsb, 1'b1);

    // Random traffic over a few lines so coalescing, eviction and full lines all occur
    for (int n = 0; n < 800; n++) begin
      bit          v;
      bit          fl;
      logic [7:0]  idx;
      logic [3:0]  line;
      logic [3:0]  lane;
      v    = ($urandom_range(0, 9) < 8);
      fl   = ($urandom_range(0, 24) == 0);
      line = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      lane = 4'($urandom_range(0, 15));
      idx  = {line, lane};
      applyStimulus(v, idx, 8'($urandom_range(0, 255)), fl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proposal_sram_writer.md
Name: proposal_sram_writer

Overview:
Write-side packer placed directly upstream of the 16x128b proposal SRAM. It accepts a stream of single-byte proposals, each tagged with a vertex index, and coalesces bytes that land in the same 128b line into one SRAM write. Each write carries a per-byte keep-mask, so untouched bytes in that line are preserved. A flush handshake drains the partial line at the end of a pass.

Parameters:
ADDR_SPACE, 4, SRAM line address width (16 lines)
Q, 16, bytes per line (fixed at 16; lane index = idx[3:0])
BW, 8, bits per byte lane

Ports:
clk  input  1  clock, all state changes on posedge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input byte valid
in_ready  output  1  block can accept the input byte this cycle
in_idx  input  ADDR_SPACE+4  vertex index; [ADDR_SPACE+3:4] = line, [3:0] = byte lane
in_data  input  BW  proposal byte
flush  input  1  single-cycle request to drain the buffered line; sampled only when in_ready=1
flush_done  output  1  single-cycle pulse when the flush has completed
wsb  output  1  SRAM write strobe, active low
waddr  output  ADDR_SPACE  SRAM write line address
wdata  output  BW*Q  SRAM write data
bytemask  output  Q  SRAM byte mask; 1 = keep the old byte, 0 = write the byte

Behaviour:
- Line buffer registers: buf_addr, buf_data[BW*Q], buf_pend[Q] (1 = byte pending). State machine: EMPTY, ACC, FLUSH2.
- in_ready = 1 in EMPTY/ACC, 0 in FLUSH2, and 0 while rst_n is low.
- Accept = in_valid & in_ready. On an accepted byte, its lane is merged into the buffer. A later byte to the same lane overwrites the earlier byte; last write wins.
- All SRAM outputs are registered. A write issued "at t+1" means that wsb=0 and the write fields are valid in the cycle after the decision. The SRAM captures the write on the following edge.
- Write fields:
  - waddr = buf_addr.
  - bytemask = ~buf_pend.
  - wdata lanes = buffer byte where pending, 0 elsewhere.
  - In a cycle with no write: wsb=1, bytemask=all 1s, and wdata/waddr hold their last values.
- EMPTY:
  - Accepted byte: open the buffer at line L and go to ACC. No write is issued.
  - flush with no accept: flush_done=1 at t+1, no write issued, stay in EMPTY.
  - flush with an accept: treat as ACC-with-flush on the newly opened line.
- ACC, accepted byte for the same line:
  - Merge the byte.
  - If buf_pend becomes all 1s: write the merged line at t+1 and go to EMPTY.
- ACC, accepted byte for a different line:
  - Write the old line at t+1.
  - In the same edge, reopen the buffer with the new byte only. Stay in ACC.
- ACC with flush (for any accept, see the next three rules):
  - No accept, or a same-line accept: write the merged line at t+1, flush_done=1 at t+1, go to EMPTY.
  - Different-line accept: write the old line at t+1 and go to FLUSH2, with the buffer holding the new byte.
  - FLUSH2: write the new line at t+2, flush_done=1 at t+2, go to EMPTY.
- flush_done is high for exactly one cycle per flush. It coincides with the final write of that flush, if there is one.
- Asynchronous reset, at any time including mid-flush:
  - Outputs: wsb=1, bytemask=all 1s, waddr=0, wdata=0, flush_done=0.
  - State and buffer: state=EMPTY, buf_pend=0; buffered bytes are discarded.
  - No write or flush_done is issued after reset is released unless new input arrives.
- Throughput is one byte per cycle with no stalls, except the single FLUSH2 cycle.
- The block issues at most one SRAM write per cycle.

Test Plan:
- Reset: hold rst_n=0 -> wsb=1, bytemask=16'hFFFF, in_ready=0. Release -> in_ready=1, no write issued.
- Coalesce: accept (0x31,AA), (0x35,BB), (0x31,CC), then (0x52,11).
  - Required: exactly one write, in the cycle after 0x52 is accepted.
  - Write fields: waddr=3, bytemask=16'hFFDD, wdata byte1=CC, byte5=BB, all other bytes 0.
- Full line: accept idx 0x70..0x7F on consecutive cycles with data=idx.
  - Required: wsb=0 one cycle after 0x7F, waddr=7, bytemask=0, wdata=0x7F7E...7170.
  - A following byte to 0x80 causes no write.
- Flush, same line: buffer holds (0x20,5A). Pulse flush together with (0x21,6B).
  - Required at t+1: one write with waddr=2, bytemask=16'hFFFC, wdata low bytes=6B5A, and flush_done=1.
- Flush, different line: buffer holds (0x20,5A). Pulse flush together with (0x91,77).
  - t+1: write waddr=2, bytemask=16'hFFFE; in_ready=0.
  - t+2: write waddr=9, bytemask=16'hFFFD, byte1=77; flush_done=1; in_ready=1.
- Reset mid-flush: assert rst_n=0 during FLUSH2.
  - Required: wsb=1 immediately and no flush_done.
  - After release, flush alone gives flush_done at t+1 with no write.
